// File: rtl/reg_pipe_hs.sv
// N-stage valid/ready pipeline register.
// Empty stages always accept, so data packs toward the output; supports flush and an occupancy count.
module reg_pipe_hs #(
  parameter int             W       = 8,
  parameter int             STAGES  = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rest,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [W-1:0]                  in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [W-1:0]                  out_data,
  input  logic                          out_ready,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] tk;
  logic [STAGES-1:0] src_v;
  logic [W-1:0]      d_q   [STAGES];
  logic [W-1:0]      d_d   [STAGES];
  logic [W-1:0]      src_d [STAGES];
  logic [CW-1:0]     count_q, count_d;
  logic              accept, emit;

  // A stage can take new data when it, or any stage downstream of it, has a
  // free slot, or when the last stage is draining. This is the take chain
  // written in closed form.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    assign tk[gi] = out_ready | ~(&v_q[STAGES-1:gi]);
    if (gi == 0) begin : g_head
      assign src_v[gi] = in_valid;
      assign src_d[gi] = in_data;
    end else begin : g_body
      assign src_v[gi] = v_q[gi-1];
      assign src_d[gi] = d_q[gi-1];
    end
  end

  assign in_ready  = tk[0] & ~flush & ~rest;
  assign out_valid = v_q[STAGES-1] & ~flush;
  assign out_data  = d_q[STAGES-1];
  assign count     = count_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (tk[i]) begin
        v_d[i] = src_v[i];
        // A bubble moving in leaves the old data in place.
        if (src_v[i]) begin
          d_d[i] = src_d[i];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= RST_VAL;
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Bench for reg_pipe_hs: a queue model with per-item stage positions,
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_reg_pipe_hs;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rest, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;
  logic       ff_in_ready, ff_out_valid;
  logic [7:0] ff_out_data;
  logic [1:0] ff_count;

  int checks = 0;
  int errors = 0;

  // Model: queue of in-flight items with the stage index each occupies.
  logic [7:0] md[$];
  int         mp[$];
  bit         pristine;

  always #5 clk = ~clk;

  reg_pipe_hs #(.W(8), .STAGES(S), .RST_VAL(8'h00)) dut (
    .clk(clk), .rest(rest), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count));

  reg_pipe_hs #(.W(8), .STAGES(S), .RST_VAL(8'hFF)) dut_ff (
    .clk(clk), .rest(rest), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ff_in_ready), .out_valid(ff_out_valid), .out_data(ff_out_data),
    .out_ready(out_ready), .count(ff_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model to the
  // state it must have after the coming rising edge.
  always @(negedge clk) begin
    if (rest) begin
      md.delete();
      mp.delete();
      pristine = 1'b1;
      chk("m_rst_out_valid", 32'(out_valid), 32'd0);
      chk("m_rst_in_ready", 32'(in_ready), 32'd0);
      chk("m_rst_count", 32'(count), 32'd0);
      chk("m_rst_out_data", 32'(out_data), 32'h00);
      chk("m_rst_ff_out_data", 32'(ff_out_data), 32'hFF);
    end else begin
      bit exp_ir, exp_ov, pop;
      int ahead;
      exp_ir = !flush && (out_ready || md.size() < S);
      exp_ov = !flush && md.size() > 0 && mp[0] == S - 1;
      chk("m_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
      chk("m_count", 32'(count), 32'(md.size()));
      if (exp_ov) chk("m_out_data", 32'(out_data), 32'(md[0]));
      else if (pristine) chk("m_idle_out_data", 32'(out_data), 32'h00);
      if (flush) begin
        md.delete();
        mp.delete();
      end else begin
        pop = exp_ov && out_ready;
        if (pop) begin
          $display("xfer out data=%02h", md[0]);
          void'(md.pop_front());
          void'(mp.pop_front());
        end
        ahead = S;
        for (int k = 0; k < mp.size(); k++) begin
          mp[k] = (mp[k] + 1 < ahead - 1) ? mp[k] + 1 : ahead - 1;
          ahead = mp[k];
        end
        if (in_valid && exp_ir) begin
          $display("xfer in  data=%02h", in_data);
          md.push_back(in_data);
          mp.push_back(0);
          pristine = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic drain();
    int n;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (count != 2'd0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rest = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ff_out_data", 32'(ff_out_data), 32'hFF);
    rest = 1'b0;

    // 1: streaming, latency 3
    drive(1'b1, 8'h11, 1'b1, 1'b0); mid(); chk("t1_in_ready", 32'(in_ready), 32'd1);
    step(); drive(1'b1, 8'h22, 1'b1, 1'b0); mid(); chk("t1_ov_c1", 32'(out_valid), 32'd0);
    step(); drive(1'b1, 8'h33, 1'b1, 1'b0); mid(); chk("t1_ov_c2", 32'(out_valid), 32'd0);
    step(); drive(1'b1, 8'h44, 1'b1, 1'b0); mid(); chk("t1_ov_c3", 32'(out_valid), 32'd1);
    chk("t1_d11", 32'(out_data), 32'h11);
    step(); drive(1'b0, 8'h00, 1'b1, 1'b0); mid(); chk("t1_d22", 32'(out_data), 32'h22);
    step(); mid(); chk("t1_d33", 32'(out_data), 32'h33);
    step(); mid(); chk("t1_d44", 32'(out_data), 32'h44);
    step(); mid(); chk("t1_ov_end", 32'(out_valid), 32'd0);
    drain();

    // 2: backpressure then release
    step(); drive(1'b1, 8'hA1, 1'b0, 1'b0);
    step(); drive(1'b1, 8'hA2, 1'b0, 1'b0);
    step(); drive(1'b1, 8'hA3, 1'b0, 1'b0);
    step(); drive(1'b1, 8'hA4, 1'b0, 1'b0); mid();
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    chk("t2_count_full", 32'(count), 32'd3);
    chk("t2_hold_a1", 32'(out_data), 32'hA1);
    step(); drive(1'b1, 8'hA4, 1'b1, 1'b0); mid();
    chk("t2_in_ready_rel", 32'(in_ready), 32'd1);
    chk("t2_a1", 32'(out_data), 32'hA1);
    step(); drive(1'b0, 8'h00, 1'b1, 1'b0); mid(); chk("t2_a2", 32'(out_data), 32'hA2);
    step(); mid(); chk("t2_a3", 32'(out_data), 32'hA3);
    step(); mid(); chk("t2_a4", 32'(out_data), 32'hA4);
    drain();

    // 3: bubbles collapse toward the output
    step(); drive(1'b1, 8'h01, 1'b0, 1'b0);
    step(); drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step(); drive(1'b1, 8'h02, 1'b0, 1'b0);
    step(); drive(1'b0, 8'h00, 1'b0, 1'b0);
    step(); mid();
    chk("t3_count", 32'(count), 32'd2);
    chk("t3_out01", 32'(out_data), 32'h01);

    // 5: flush beats in_valid and out_ready
    step(); drive(1'b1, 8'h55, 1'b1, 1'b1); mid();
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    step(); drive(1'b0, 8'h00, 1'b1, 1'b0); mid();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_ov_after", 32'(out_valid), 32'd0);

    // 4: full pipe with simultaneous push/pop
    step(); drive(1'b1, 8'hB1, 1'b0, 1'b0);
    step(); drive(1'b1, 8'hB2, 1'b0, 1'b0);
    step(); drive(1'b1, 8'hB3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(); drive(1'b1, 8'hB4 + 8'(i), 1'b1, 1'b0); mid();
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      chk("t4_count", 32'(count), 32'd3);
    end
    drain();

    // random mix, checked by the model
    for (int i = 0; i < 80; i++) begin
      step();
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    // 6: async reset between edges
    step(); drive(1'b1, 8'hC1, 1'b1, 1'b0);
    step(); drive(1'b1, 8'hC2, 1'b1, 1'b0);
    step(); drive(1'b1, 8'hC3, 1'b1, 1'b0);
    step(); drive(1'b0, 8'h00, 1'b1, 1'b0);
    #2 rest = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_data", 32'(out_data), 32'h00);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_ff_out_data", 32'(ff_out_data), 32'hFF);
    step(); step();
    #2 rest = 1'b0;
    #1;
    chk("t6_ff_after", 32'(ff_out_data), 32'hFF);
    chk("t6_ff_ov_after", 32'(ff_out_valid), 32'd0);
    step(); drive(1'b1, 8'hD1, 1'b1, 1'b0);
    step(); drive(1'b0, 8'h00, 1'b1, 1'b0);
    step(); step(); mid();
    chk("t6_first_after_rst", 32'(out_data), 32'hD1);
    drain();

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
